// File: rtl/spi_ctrl_pkg.sv
// Shared constants and types for the SPI transfer controller: coprocessor
// register map, status/CTRL bit positions and the transfer FSM state type.
package spi_ctrl_pkg;

  localparam int W_REG = 5;

  localparam logic [W_REG-1:0] SPI_A_TXDATA = 5'd2;
  localparam logic [W_REG-1:0] SPI_A_RXDATA = 5'd4;
  localparam logic [W_REG-1:0] SPI_A_STATUS = 5'd6;
  localparam logic [W_REG-1:0] SPI_A_CTRL   = 5'd7;

  localparam int ST_TX_EMPTY  = 0;
  localparam int ST_TX_FULL   = 1;
  localparam int ST_RX_EMPTY  = 2;
  localparam int ST_RX_FULL   = 3;
  localparam int ST_BUSY      = 4;
  localparam int ST_RX_OVF    = 5;
  localparam int ST_TIMEOUT   = 6;
  localparam int ST_RX_COUNT  = 8;
  localparam int ST_TX_COUNT  = 16;

  localparam int CTRL_CLR_STICKY = 0;
  localparam int CTRL_FLUSH      = 1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT
  } xfer_state_e;

endpackage

// File: rtl/spi_xfer_ctrl_if.sv
// CPU coprocessor port plus spi engine handshake, bundled for spi_xfer_ctrl.
// The slave modport is the controller's view; master is the CPU/engine side.
interface spi_xfer_ctrl_if #(
  parameter int W_DATA = 32
);

  logic                          cpu_req;
  logic                          cpu_wr;
  logic [spi_ctrl_pkg::W_REG-1:0] cpu_addr;
  logic [W_DATA-1:0]             cpu_wdata;
  logic [W_DATA-1:0]             cpu_rdata;
  logic                          cpu_stall;
  logic                          spi_tx_ready;
  logic [W_DATA-1:0]             spi_tx_data;
  logic                          spi_tx_valid;
  logic [W_DATA-1:0]             spi_rx_data;
  logic                          spi_rx_valid;
  logic                          busy;

  modport slave (
    input  cpu_req, cpu_wr, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  spi_tx_ready, spi_rx_data, spi_rx_valid,
    output spi_tx_data, spi_tx_valid, busy
  );

  modport master (
    output cpu_req, cpu_wr, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output spi_tx_ready, spi_rx_data, spi_rx_valid,
    input  spi_tx_data, spi_tx_valid, busy
  );

endinterface

// File: rtl/spi_xfer_ctrl_sync_fifo.sv
// Single-clock FIFO with flush; head word is presented combinationally and
// reads as zero when empty. Caller guarantees no push-when-full without pop.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr_reg, rptr_reg;
  logic [AW-1:0]    wptr_next, rptr_next, waddr;
  logic [CW-1:0]    count_reg, count_next;

  // A push coinciding with flush lands in slot 0 so the word survives the flush.
  assign waddr = flush ? '0 : wptr_reg;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (push && waddr == AW'(gi)) begin
          mem[gi] <= din;
        end
      end
    end
  endgenerate

  always_comb begin
    wptr_next  = wptr_reg + AW'(push);
    rptr_next  = rptr_reg + AW'(pop);
    count_next = count_reg + CW'(push) - CW'(pop);
    if (flush) begin
      wptr_next  = AW'(push);
      rptr_next  = '0;
      count_next = CW'(push);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_reg  <= '0;
      rptr_reg  <= '0;
      count_reg <= '0;
    end else begin
      wptr_reg  <= wptr_next;
      rptr_reg  <= rptr_next;
      count_reg <= count_next;
    end
  end

  assign empty = (count_reg == '0);
  assign full  = (count_reg == CW'(DEPTH));
  assign count = count_reg;
  assign dout  = empty ? '0 : mem[rptr_reg];

endmodule

// File: rtl/spi_xfer_ctrl.sv
// Clocked scheduler between the CPU coprocessor port and the spi engine.
// Define SPI_XFER_TIMEOUT_EN to abort a WAIT after TIMEOUT_CYC cycles.
module spi_xfer_ctrl
  import spi_ctrl_pkg::*;
#(
  parameter int W_DATA      = 32,
  parameter int TX_DEPTH    = 4,
  parameter int RX_DEPTH    = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input logic            clk,
  input logic            rst,
  spi_xfer_ctrl_if.slave bus
);

  localparam int TX_CW = $clog2(TX_DEPTH) + 1;
  localparam int RX_CW = $clog2(RX_DEPTH) + 1;

  if (TX_DEPTH < 2 || (TX_DEPTH & (TX_DEPTH - 1)) != 0 ||
      RX_DEPTH < 2 || (RX_DEPTH & (RX_DEPTH - 1)) != 0 || TIMEOUT_CYC < 1) begin : g_bad_params
    $error("spi_xfer_ctrl: depths must be powers of two >= 2 and TIMEOUT_CYC >= 1");
  end

  xfer_state_e       state_reg, state_next;
  logic              tx_full, tx_empty, rx_full, rx_empty;
  logic [TX_CW-1:0]  tx_count;
  logic [RX_CW-1:0]  rx_count;
  logic [W_DATA-1:0] tx_head, rx_head, tx_data_reg, status;
  logic              hit_tx, hit_rx, hit_ctrl;
  logic              stall, accept, tx_push, tx_pop, rx_push, rx_pop, rx_attempt;
  logic              ctrl_wr, flush, clr_sticky, ovf_set;
  logic              rx_ovf_reg, timeout_hit, timeout_flag;

  assign hit_tx   = (bus.cpu_addr == SPI_A_TXDATA);
  assign hit_rx   = (bus.cpu_addr == SPI_A_RXDATA);
  assign hit_ctrl = (bus.cpu_addr == SPI_A_CTRL);

  // Stall looks only at registered FIFO state; engine activity this cycle never releases it.
  assign stall  = bus.cpu_req & ((bus.cpu_wr & hit_tx & tx_full) |
                                 (!bus.cpu_wr & hit_rx & rx_empty));
  assign accept = bus.cpu_req & !stall;

  assign tx_push    = accept & bus.cpu_wr & hit_tx;
  assign rx_pop     = accept & !bus.cpu_wr & hit_rx;
  assign ctrl_wr    = accept & bus.cpu_wr & hit_ctrl;
  assign flush      = ctrl_wr & bus.cpu_wdata[CTRL_FLUSH];
  assign clr_sticky = ctrl_wr & bus.cpu_wdata[CTRL_CLR_STICKY];

  assign tx_pop     = (state_reg == LOAD);
  assign rx_attempt = (state_reg == WAIT) & bus.spi_rx_valid;
  assign rx_push    = rx_attempt & (!rx_full | rx_pop);
  assign ovf_set    = rx_attempt & rx_full & !rx_pop;

  sync_fifo #(.WIDTH(W_DATA), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (tx_push),
    .pop   (tx_pop),
    .din   (bus.cpu_wdata),
    .dout  (tx_head),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

  sync_fifo #(.WIDTH(W_DATA), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (rx_push),
    .pop   (rx_pop),
    .din   (bus.spi_rx_data),
    .dout  (rx_head),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (!tx_empty && bus.spi_tx_ready) state_next = LOAD;
      LOAD:    state_next = WAIT;
      WAIT:    if (bus.spi_rx_valid || timeout_hit) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_data_reg <= '0;
    end else if (state_reg == LOAD) begin
      tx_data_reg <= tx_head;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_ovf_reg <= 1'b0;
    end else if (ovf_set) begin
      rx_ovf_reg <= 1'b1;
    end else if (clr_sticky) begin
      rx_ovf_reg <= 1'b0;
    end
  end

`ifdef SPI_XFER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] to_cnt_reg;
  logic            timeout_reg;

  always_ff @(posedge clk) begin
    if (rst || state_reg != WAIT) begin
      to_cnt_reg <= '0;
    end else begin
      to_cnt_reg <= to_cnt_reg + 1'b1;
    end
  end

  // A reply arriving on the last allowed cycle still wins over the abort.
  assign timeout_hit = (state_reg == WAIT) && !bus.spi_rx_valid &&
                       (to_cnt_reg == TO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      timeout_reg <= 1'b0;
    end else if (timeout_hit) begin
      timeout_reg <= 1'b1;
    end else if (clr_sticky) begin
      timeout_reg <= 1'b0;
    end
  end

  assign timeout_flag = timeout_reg;
`else
  assign timeout_hit  = 1'b0;
  assign timeout_flag = 1'b0;
`endif

  always_comb begin
    status                            = '0;
    status[ST_TX_EMPTY]               = tx_empty;
    status[ST_TX_FULL]                = tx_full;
    status[ST_RX_EMPTY]               = rx_empty;
    status[ST_RX_FULL]                = rx_full;
    status[ST_BUSY]                   = bus.busy;
    status[ST_RX_OVF]                 = rx_ovf_reg;
    status[ST_TIMEOUT]                = timeout_flag;
    status[ST_RX_COUNT +: 8]          = 8'(rx_count);
    status[ST_TX_COUNT +: 8]          = 8'(tx_count);
  end

  always_comb begin
    bus.cpu_rdata = '0;
    if (hit_rx) begin
      bus.cpu_rdata = rx_head;
    end else if (bus.cpu_addr == SPI_A_STATUS) begin
      bus.cpu_rdata = status;
    end
  end

  assign bus.cpu_stall    = stall;
  assign bus.busy         = (state_reg != IDLE) | !tx_empty;
  assign bus.spi_tx_valid = (state_reg == LOAD);
  assign bus.spi_tx_data  = (state_reg == LOAD) ? tx_head : tx_data_reg;

endmodule
